// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Fetch stage feeding the instruction decoder. Holds the PC,
//                issues word reads to a 1-cycle-latency synchronous ROM and
//                buffers returned words with their PC in a 2-entry FIFO.
//                A redirect squashes every in-flight and buffered fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc
);

    localparam logic [31:0] c_pc_step = 32'd4;

    logic [31:0] r_fetch_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    logic [1:0]  r_count;
    logic        r_head;
    logic [31:0] r_fifo_data [2];
    logic [31:0] r_fifo_pc   [2];

    logic [2:0]  w_occupancy;
    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic        w_wr_idx;
    logic [31:0] w_target;

    // Word-align the redirect target; the low two bits are meaningless.
    assign w_target    = redirect_pc & 32'hFFFF_FFFC;

    // Buffered words plus the outstanding ROM read never exceed two, so an
    // issue is only allowed when a slot is free now or is being freed by a pop.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_pop       = instr_valid & instr_ready;
    assign w_push      = r_inflight & ~redirect_valid;
    assign w_issue     = ~redirect_valid & ((w_occupancy < 3'd2) | w_pop);
    assign w_wr_idx    = r_head ^ r_count[0];

    // Gating with rst_n makes the strobe drop the instant reset asserts.
    assign imem_en     = w_issue & rst_n;
    assign imem_addr   = r_fetch_pc[IMEM_AW+1:2];

    assign instr_valid = (r_count != 2'd0);
    assign instr       = r_fifo_data[r_head];
    assign instr_pc    = r_fifo_pc[r_head];

    // PC and in-flight tracking; a redirect drops the pending ROM return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
        end else if (redirect_valid) begin
            r_fetch_pc    <= w_target;
            r_inflight    <= 1'b0;
        end else begin
            r_inflight    <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + c_pc_step;
            end
        end
    end

    // FIFO occupancy and head pointer; a redirect flushes after any pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
        end else if (redirect_valid) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
        end else begin
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) begin
                r_head <= ~r_head;
            end
        end
    end

    // FIFO storage; returned word is written behind any entry still buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_data[0] <= 32'h0;
            r_fifo_data[1] <= 32'h0;
            r_fifo_pc[0]   <= 32'h0;
            r_fifo_pc[1]   <= 32'h0;
        end else if (w_push) begin
            r_fifo_data[w_wr_idx] <= imem_rdata;
            r_fifo_pc[w_wr_idx]   <= r_inflight_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Randomized and directed stimulus for instruction_fetch,
//                checked against a queue-based model of outstanding fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam int          c_aw       = 30;
    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    logic              clk;
    logic              rst_n;
    logic              imem_en;
    logic [c_aw-1:0]   imem_addr;
    logic [31:0]       imem_rdata;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [31:0]       instr_pc;

    instruction_fetch #(
        .RESET_PC (c_reset_pc),
        .IMEM_AW  (c_aw)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: ROM[k] = 0x1000_0000 + k, one cycle of read latency.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'h1000_0000 + {2'b00, imem_addr};
    end

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'h1000_0000 + (pc >> 2);
    endfunction

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: every fetch issued and not yet consumed, in program order, with
    // the cycle it was issued. A word is visible two cycles after its issue.
    typedef struct {
        logic [31:0] pc;
        int unsigned c;
    } fetch_t;

    fetch_t      q[$];
    logic [31:0] fpc = c_reset_pc;
    int unsigned cyc = 0;
    int          n8  = 0;

    function automatic bit head_is(input logic [31:0] p);
        return (q.size() > 0) && (cyc - q[0].c >= 2) && (q[0].pc == p);
    endfunction

    task automatic step(input logic rn, input logic rdy, input logic rv, input logic [31:0] rpc);
        logic ev, hs, een;
        @(negedge clk);
        rst_n          = rn;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        if (!rn) begin
            check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
            check_eq("rst_en",    {31'b0, imem_en},     32'd0);
            check_eq("rst_instr", instr,                32'd0);
            check_eq("rst_pc",    instr_pc,             32'd0);
            q.delete();
            fpc = c_reset_pc;
        end else begin
            ev = (q.size() > 0) && (cyc - q[0].c >= 2);
            check_eq("valid", {31'b0, instr_valid}, {31'b0, ev});
            if (ev) begin
                check_eq("instr_pc", instr_pc, q[0].pc);
                check_eq("instr",    instr,    rom_word(q[0].pc));
            end
            hs  = ev && rdy;
            een = !rv && ((q.size() < 2) || hs);
            check_eq("imem_en", {31'b0, imem_en}, {31'b0, een});
            if (een) check_eq("imem_addr", {2'b00, imem_addr}, {2'b00, fpc[31:2]});
            check_eq("count_le2", {31'b0, (dut.r_count <= 2'd2)}, 32'd1);
            if (hs) begin
                if (q[0].pc == 32'h8) n8++;
                void'(q.pop_front());
            end
            if (rv) begin
                q.delete();
                fpc = rpc & 32'hFFFF_FFFC;
            end else if (een) begin
                q.push_back('{pc: fpc, c: cyc});
                fpc = fpc + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        bit hit;
        rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        // Startup stream with the decoder always ready
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);

        // Decoder stall mid-stream, then resume
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
        check_eq("stall_full_en", {31'b0, imem_en}, 32'd0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);

        // Redirect with the FIFO full to an unaligned target
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        step(1, 0, 1, 32'h0000_0102);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);

        // Redirect in the same cycle as the handshake of pc 0x8
        step(0, 0, 0, 0);
        n8  = 0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (head_is(32'h8)) begin
                step(1, 1, 1, 32'h0000_0200);
                hit = 1'b1;
            end else begin
                step(1, 1, 0, 0);
            end
        end
        check_eq("hs_redirect_hit", {31'b0, hit}, 32'd1);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
        check_eq("pc8_once", n8, 32'd1);

        // PC wrap across the top of the address space
        step(1, 1, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);

        // Reset mid-stream with a read in flight
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);

        // Randomized traffic: backpressure, redirects and occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic rn, rdy, rv;
            rn  = ($urandom_range(0, 199) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            step(rn, rdy, rv, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
